// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Define TC_AUTORELOAD_EN to enable MODE 01 auto-reload; otherwise every expiry is one-shot.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t state, state_n;
    logic en, im, irq_flag, reload;
    logic [1:0] mode;
    logic [31:0] preset, count;
    logic ctrl_wr, preset_wr, expire;
    assign ctrl_wr   = we && addr == 2'd0;
    assign preset_wr = we && addr == 2'd1;
    assign expire    = state == CNT && en && count <= 32'd1;
`ifdef TC_AUTORELOAD_EN
    assign reload = mode == 2'b01;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            mode <= 2'b00;
        else if (ctrl_wr)
            mode <= wdata[2:1];
`else
    assign reload = 1'b0;
    assign mode   = 2'b00;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = en ? LOAD : IDLE;
            LOAD:    state_n = CNT;
            CNT:     state_n = !en ? IDLE : expire ? INT : CNT;
            default: state_n = reload ? LOAD : IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            en       <= 1'b0;
            im       <= 1'b0;
            irq_flag <= 1'b0;
            preset   <= 32'd0;
            count    <= 32'd0;
        end else begin
            if (state == LOAD)
                count <= preset;
            else if (state == CNT && en)
                count <= expire ? 32'd0 : count - 32'd1;
            if (expire)
                irq_flag <= 1'b1;
            else if (state == INT && reload)
                irq_flag <= 1'b0;
            // Software CTRL writes take priority over the hardware EN clear and flag updates
            if (ctrl_wr) begin
                en       <= wdata[0];
                im       <= wdata[3];
                irq_flag <= 1'b0;
            end else if (state == INT && !reload)
                en <= 1'b0;
            if (preset_wr)
                preset <= wdata;
        end
    always_comb
        rdata = addr == 2'd0 ? {28'd0, im, mode, en} :
                addr == 2'd1 ? preset :
                addr == 2'd2 ? count : 32'd0;
    assign irq = irq_flag & im;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for timer_counter.
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:2]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    int checks = 0;
    int failures = 0;

    timer_counter dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wdata = d;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            checks++;
            if (d !== 32'd0) begin
                failures++;
                $display("FAIL reset_rdata addr=%0d got=%h exp=%h", a, d, 32'd0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 8; e++) step();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd4) begin
            failures++;
            $display("FAIL midreset_pre_count got=%h exp=%h", d, 32'd4);
        end
        reset = 1'b0;
        #1;
        for (int a = 0; a < 3; a++) begin
            rd(a[1:0], d);
            checks++;
            if (d !== 32'd0) begin
                failures++;
                $display("FAIL midreset_reg addr=%0d got=%h exp=%h", a, d, 32'd0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL midreset_irq got=%b exp=0", irq);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 6; e++) step();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL midreset_after count=%h irq=%b exp count=0 irq=0", d, irq);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e >= 2 && e <= 6) begin
                rd(2'd2, d);
                checks++;
                if (d !== 32'(7 - e)) begin
                    failures++;
                    $display("FAIL oneshot_count edge=%0d got=%h exp=%h", e, d, 32'(7 - e));
                end
            end
            checks++;
            if (irq !== (e >= 7)) begin
                failures++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", e, irq, e >= 7);
            end
            if (e == 7 || e == 8) begin
                rd(2'd0, d);
                checks++;
                if (d !== (e == 7 ? 32'h9 : 32'h8)) begin
                    failures++;
                    $display("FAIL oneshot_ctrl edge=%0d got=%h exp=%h", e, d, e == 7 ? 32'h9 : 32'h8);
                end
            end
        end
        wr(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int e = 1; e <= 4; e++) step();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL mask_int count=%h irq=%b exp count=0 irq=0", d, irq);
        end
        step();
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL mask_ctrl got=%h exp=%h", d, 32'd0);
        end
        wr(2'd0, 32'h8);
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (irq !== 1'b0) begin
                failures++;
                $display("FAIL mask_unmask_irq got=%b exp=0", irq);
            end
            step();
        end
    endtask

    task automatic test_disable_edit();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 5; e++) step();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd5) begin
            failures++;
            $display("FAIL edit_count5 got=%h exp=%h", d, 32'd5);
        end
        wr(2'd1, 32'd2);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd4) begin
            failures++;
            $display("FAIL edit_keep_count got=%h exp=%h", d, 32'd4);
        end
        wr(2'd0, 32'h8);
        for (int e = 0; e < 4; e++) begin
            step();
            rd(2'd2, d);
            checks++;
            if (d !== 32'd3) begin
                failures++;
                $display("FAIL edit_frozen got=%h exp=%h", d, 32'd3);
            end
        end
        wr(2'd0, 32'h9);
        step();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd3) begin
            failures++;
            $display("FAIL edit_load_edge got=%h exp=%h", d, 32'd3);
        end
        step();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd2) begin
            failures++;
            $display("FAIL edit_reload got=%h exp=%h", d, 32'd2);
        end
    endtask

    task automatic test_preset_zero();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 4; e++) begin
            step();
            rd(2'd2, d);
            checks++;
            if (d !== 32'd0 || irq !== (e >= 3)) begin
                failures++;
                $display("FAIL zero_preset edge=%0d count=%h irq=%b exp count=0 irq=%b", e, d, irq, e >= 3);
            end
        end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'hA5A5_0001);
        wr(2'd2, 32'h1234);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL count_write got=%h exp=%h", d, 32'd0);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL addr3_read got=%h exp=%h", d, 32'd0);
        end
        rd(2'd1, d);
        checks++;
        if (d !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL preset_readback got=%h exp=%h", d, 32'hA5A5_0001);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL ctrl_untouched got=%h exp=%h", d, 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 3; e++) step();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL b2b_int_irq got=%b exp=1", irq);
        end
        wr(2'd0, 32'h9);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h9 || irq !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sw_wins ctrl=%h irq=%b exp ctrl=9 irq=0", d, irq);
        end
        for (int e = 0; e < 3; e++) step();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL b2b_rearm_irq got=%b exp=1", irq);
        end
    endtask

    task automatic test_mode();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
`ifdef TC_AUTORELOAD_EN
        rd(2'd0, d);
        checks++;
        if (d !== 32'hB) begin
            failures++;
            $display("FAIL auto_ctrl got=%h exp=%h", d, 32'hB);
        end
        for (int e = 1; e <= 16; e++) begin
            step();
            rd(2'd2, d);
            checks++;
            if (irq !== (e % 5 == 0)) begin
                failures++;
                $display("FAIL auto_irq edge=%0d got=%b exp=%b", e, irq, e % 5 == 0);
            end
            if (e >= 2) begin
                checks++;
                if (d !== (e % 5 == 2 ? 32'd3 : e % 5 == 3 ? 32'd2 : e % 5 == 4 ? 32'd1 : 32'd0)) begin
                    failures++;
                    $display("FAIL auto_count edge=%0d got=%h", e, d);
                end
            end
        end
`else
        rd(2'd0, d);
        checks++;
        if (d !== 32'h9) begin
            failures++;
            $display("FAIL mode_ctrl got=%h exp=%h", d, 32'h9);
        end
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (irq !== (e >= 5)) begin
                failures++;
                $display("FAIL mode_oneshot_irq edge=%0d got=%b exp=%b", e, irq, e >= 5);
            end
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h8) begin
            failures++;
            $display("FAIL mode_en_cleared got=%h exp=%h", d, 32'h8);
        end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_reset_midcount();
        test_oneshot();
        test_mask();
        test_disable_edit();
        test_preset_zero();
        test_ignored_writes();
        test_back_to_back();
        test_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer that acts as the responder for CPU word loads and stores issued by the MEM stage through the system bridge. The read data it returns is the load data that travels down the pipeline to writeback, and its interrupt output drives one CP0 hardware interrupt line. It provides two modes: one-shot with a held interrupt, and periodic auto-reload with a one-cycle interrupt pulse.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  [3:2]  word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `we`  in  1  write strobe from the bridge, sampled on the rising edge.
- `wdata`  in  32  store data.
- `rdata`  out  32  read data for the register selected by `addr`; combinational.
- `irq`  out  1  interrupt request to CP0.

## Operation
- CTRL register:
  - bit0 EN (enable).
  - bits[2:1] MODE: 00 = one-shot, 01 = auto-reload. Values 10 and 11 behave as 00.
  - bit3 IM (interrupt mask; 1 = irq allowed).
  - bits[31:4] read as 0.
- PRESET register: 32-bit reload value, read/write.
- COUNT register: 32-bit current count, read-only. Writes to COUNT are ignored.
- Reads at `addr` 3 return 0. Writes at `addr` 3 are ignored.
- Internal flag `irq_flag`. Output `irq = irq_flag & IM`.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds its value.
    - Else if COUNT > 1, COUNT <= COUNT - 1.
    - Else (COUNT is 1 or 0), COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE 00: EN <= 0, go to IDLE. irq_flag stays 1 until software clears it.
  - INT, MODE 01: irq_flag <= 0, go to LOAD.
- Software actions:
  - A write to CTRL updates EN, MODE and IM, and clears irq_flag.
  - A write to PRESET updates PRESET only; COUNT is unchanged until the next LOAD.
- Boundary cases:
  - A CTRL write in the same cycle as the INT-state hardware clear of EN: the software-written value wins.
  - A CTRL write with EN = 0 while in CNT or LOAD: the FSM goes to IDLE on the following edge.
  - PRESET = 0: the FSM goes LOAD -> CNT -> INT with no wrap; COUNT never underflows.
  - PRESET = 0xFFFF_FFFF: counts down normally; no overflow is possible.
- Reset (asserted at any time, including mid-count): CTRL, PRESET, COUNT = 0; state = IDLE; irq_flag = 0.

## Timing
- Reset values: `rdata` follows `addr` (0 for every address); `irq` = 0.
- Write latency: the register takes its new value on the edge where `we` is sampled. `rdata` shows it in the following cycle.
- Edge numbering: the enabling CTRL write is edge 0, PRESET = N ≥ 1.
  - Edge 1: state LOAD.
  - Edge 2: state CNT, COUNT = N.
  - Edge 2+k: COUNT = N - k.
  - Edge N+1: COUNT = 1.
  - Edge N+2: state INT, COUNT = 0, irq_flag = 1.
- PRESET = 0: INT is reached at edge 3.
- Auto-reload: irq_flag is high for exactly 1 cycle. Pulses repeat every N+2 cycles: edges N+2, 2N+4, and so on.
- One-shot: irq stays high from edge N+2 until the edge that samples a CTRL write. CTRL reads EN = 0 from edge N+3.

## Configuration
- Macro `TC_AUTORELOAD_EN`.
- Defined: MODE 01 gives auto-reload behaviour as specified above.
- Undefined:
  - MODE bits are not stored and read as 00.
  - Every INT transition behaves as one-shot.
  - Mode-01 auto-reload logic is absent.

## Test plan
- Reset mid-count: PRESET = 10, EN = 1; pull `reset` low at COUNT = 4 -> all registers 0 immediately, `irq` = 0, FSM in IDLE; no activity after release.
- One-shot: PRESET = 5, then CTRL = 0x9 -> COUNT reads 5, 4, 3, 2, 1 on edges 2–6. `irq` rises at edge 7 and holds. CTRL reads 0x8. Writing CTRL = 0x8 drops `irq` on that edge.
- Auto-reload (macro defined): PRESET = 3, CTRL = 0xB -> `irq` is 1-cycle pulses at edges 5, 10, 15. COUNT reads 0 during INT and 3 after each reload.
- Mask: PRESET = 2, CTRL = 0x1 -> INT at edge 4 with `irq` = 0. Then CTRL = 0x8 -> `irq` stays 0, because the CTRL write cleared irq_flag.
- Disable and PRESET edit mid-count: PRESET = 8, CTRL = 0x9. At COUNT = 5, write PRESET = 2 -> COUNT keeps decrementing from 5. Write CTRL = 0x8 -> COUNT freezes at its current value and the FSM goes to IDLE. Re-enable -> reload to 2.
- Edge values:
  - PRESET = 0, CTRL = 0x9 -> `irq` at edge 3; COUNT stays 0.
  - Write COUNT = 0x1234 -> ignored.
  - Read `addr` 3 -> 0.
  - With the macro undefined, CTRL = 0xB reads back 0x9 and behaves as one-shot.
